// File: rtl/video_timing_pattern_gen.sv
// video_timing_pattern_gen: VGA timing plus registered 8-bar colour pattern; define VTPG_SCROLL_EN for per-frame horizontal bar scroll
module video_timing_pattern_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int BAR_W    = 80
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic        vid_hsync,
    output logic        vid_vsync,
    output logic        vid_hblank,
    output logic        vid_vblank,
    output logic        vid_active_video,
    output logic        vid_field,
    output logic [23:0] vid_data,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int PW = $clog2(BAR_W);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [PW-1:0] PX_LAST = PW'(BAR_W - 1);

    logic [HW-1:0] hcnt;
    logic [VW-1:0] vcnt;
    logic [PW-1:0] px, start_px;
    logic [2:0]    bi, start_bi;
    logic          h_last, v_last, hs_on, vs_on, hb, vb;

    assign h_last    = hcnt == H_LAST;
    assign v_last    = vcnt == V_LAST;
    assign hs_on     = hcnt >= HS_BEG && hcnt < HS_END;
    assign vs_on     = vcnt >= VS_BEG && vcnt < VS_END;
    assign hb        = hcnt >= H_ACT;
    assign vb        = vcnt >= V_ACT;
    assign vid_field = 1'b0;

`ifdef VTPG_SCROLL_EN
    logic [PW-1:0] off_px, off_px_n;
    logic [2:0]    off_bi, off_bi_n;
    logic          frame_wrap;
    assign frame_wrap = h_last && v_last;
    assign off_px_n   = off_px == PX_LAST ? '0 : off_px + 1'b1;
    assign off_bi_n   = off_bi + 3'(off_px == PX_LAST);
    // the first line of a new frame must already start at the advanced offset
    assign start_px   = frame_wrap ? off_px_n : off_px;
    assign start_bi   = frame_wrap ? off_bi_n : off_bi;
    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            off_px <= '0;
            off_bi <= '0;
        end else if (frame_wrap) begin
            off_px <= off_px_n;
            off_bi <= off_bi_n;
        end
    end
`else
    assign start_px = '0;
    assign start_bi = '0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            hcnt             <= '0;
            vcnt             <= '0;
            px               <= '0;
            bi               <= '0;
            vid_hsync        <= ~SYNC_POL;
            vid_vsync        <= ~SYNC_POL;
            vid_hblank       <= 1'b1;
            vid_vblank       <= 1'b1;
            vid_active_video <= 1'b0;
            vid_data         <= '0;
            frame_start      <= 1'b0;
        end else begin
            hcnt             <= h_last ? '0 : hcnt + 1'b1;
            if (h_last)
                vcnt <= v_last ? '0 : vcnt + 1'b1;
            px               <= h_last ? start_px : (px == PX_LAST ? '0 : px + 1'b1);
            bi               <= h_last ? start_bi : bi + 3'(px == PX_LAST);
            vid_hsync        <= hs_on ? SYNC_POL : ~SYNC_POL;
            vid_vsync        <= vs_on ? SYNC_POL : ~SYNC_POL;
            vid_hblank       <= hb;
            vid_vblank       <= vb;
            vid_active_video <= !hb && !vb;
            // bar index bits map straight onto the R/G/B on-off pattern
            vid_data         <= (hb || vb) ? '0 : {{8{~bi[0]}}, {8{~bi[2]}}, {8{~bi[1]}}};
            frame_start      <= hcnt == '0 && vcnt == '0;
        end
    end
endmodule
